// File: rtl/mos_strength_pkg.sv
// Shared strength-bus types: driver strength enum, receiver FSM states and
// the pairwise strength resolution used to fold all drivers onto one net.
package mos_strength_pkg;

    typedef enum logic [1:0] {
        ST0 = 2'b00,
        ST1 = 2'b01,
        STZ = 2'b10,
        STX = 2'b11
    } t_strength;

    typedef enum logic [1:0] {
        S_FLOAT  = 2'b00,
        S_DRIVEN = 2'b01,
        S_KEEP   = 2'b10,
        S_CONT   = 2'b11
    } t_rx_state;

    // Associative merge: folding every driver from STZ gives the net value.
    function automatic t_strength strength_resolve(input t_strength a, input t_strength b);
        if (a == STZ) return b;
        if (b == STZ) return a;
        if (a == b)   return a;
        return STX;
    endfunction

endpackage

// File: rtl/mos_strength_filter.sv
// Glitch filter: registers the resolved net and raises accept_c once a
// candidate has been stable for FILT samples and differs from the accepted value.
module mos_strength_filter
    import mos_strength_pkg::*;
#(
    parameter int unsigned FILT = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  t_strength net_c,
    input  t_strength accepted,
    output t_strength samp,
    output logic      accept_c
);

    localparam int unsigned CW = $clog2(FILT + 1);

    logic [CW-1:0] stab_cnt;

    // stab_cnt restarts at 1 on a new sample and saturates at FILT.
    always_ff @(posedge clk) begin
        if (rst) begin
            samp     <= STZ;
            stab_cnt <= '0;
        end else begin
            samp <= net_c;
            if (net_c != samp) begin
                stab_cnt <= CW'(1);
            end else if (stab_cnt != CW'(FILT)) begin
                stab_cnt <= stab_cnt + CW'(1);
            end
        end
    end

    assign accept_c = (stab_cnt == CW'(FILT)) && (samp != accepted);

endmodule

// File: rtl/mos_strength_receiver.sv
// Strength-bus receiver: resolves all drivers, filters glitches and holds the
// last driven level through float periods with a timed bus-keeper.
module mos_strength_receiver
    import mos_strength_pkg::*;
#(
    parameter int unsigned N_DRV       = 4,
    parameter int unsigned FILT        = 2,
    parameter int unsigned KEEP_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_DRV-1:0][1:0]  drv_i,
    input  logic                   keeper_en,
    output t_strength              resolved_o,
    output logic                   level_o,
    output logic                   valid_o,
    output logic                   contention_o,
    output logic                   float_timeout_o,
    output logic                   change_o
);

    localparam int unsigned KW = $clog2(KEEP_CYCLES + 1);

    t_strength     net_c;
    t_strength     samp;
    logic          accept_c;
    t_rx_state     state;
    logic [KW-1:0] keep_cnt;

    always_comb begin
        net_c = STZ;
        for (int i = 0; i < N_DRV; i++) begin
            net_c = strength_resolve(net_c, t_strength'(drv_i[i]));
        end
    end

    mos_strength_filter #(
        .FILT (FILT)
    ) u_filter (
        .clk      (clk),
        .rst      (rst),
        .net_c    (net_c),
        .accepted (resolved_o),
        .samp     (samp),
        .accept_c (accept_c)
    );

    // Acceptance outranks keeper expiry; a dropped keeper_en ends the hold silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_FLOAT;
            keep_cnt        <= '0;
            resolved_o      <= STZ;
            level_o         <= 1'b0;
            valid_o         <= 1'b0;
            contention_o    <= 1'b0;
            float_timeout_o <= 1'b0;
            change_o        <= 1'b0;
        end else begin
            float_timeout_o <= 1'b0;
            change_o        <= 1'b0;
            if (accept_c) begin
                resolved_o   <= samp;
                contention_o <= (samp == STX);
                keep_cnt     <= '0;
                case (samp)
                    ST0, ST1: begin
                        state    <= S_DRIVEN;
                        level_o  <= (samp == ST1);
                        change_o <= ((samp == ST1) != level_o);
                        valid_o  <= 1'b1;
                    end
                    STX: begin
                        state   <= S_CONT;
                        valid_o <= 1'b0;
                    end
                    default: begin
                        if (state == S_DRIVEN && keeper_en) begin
                            state <= S_KEEP;
                        end else begin
                            state   <= S_FLOAT;
                            valid_o <= 1'b0;
                        end
                    end
                endcase
            end else if (state == S_KEEP) begin
                if (!keeper_en) begin
                    state    <= S_FLOAT;
                    valid_o  <= 1'b0;
                    keep_cnt <= '0;
                end else if (keep_cnt == KW'(KEEP_CYCLES - 1)) begin
                    state           <= S_FLOAT;
                    valid_o         <= 1'b0;
                    float_timeout_o <= 1'b1;
                    keep_cnt        <= '0;
                end else begin
                    keep_cnt <= keep_cnt + KW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mos_strength_receiver.sv
// Self-checking bench for mos_strength_receiver: directed scenarios plus
// randomized driver patterns compared each cycle against a behavioural model.
module tb_mos_strength_receiver;
    import mos_strength_pkg::*;

    localparam int unsigned N_DRV       = 4;
    localparam int unsigned FILT        = 2;
    localparam int unsigned KEEP_CYCLES = 8;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  keeper_en = 1'b1;
    logic [N_DRV-1:0][1:0] drv = '1;
    t_strength             resolved_o;
    logic                  level_o, valid_o, contention_o, float_timeout_o, change_o;

    int checks   = 0;
    int failures = 0;

    // behavioural model state
    logic [1:0] hist[$];
    logic [1:0] m_res;
    logic       m_level, m_valid, m_cont, m_tmo, m_chg;
    logic       m_driving, m_keeping;
    int         m_left;

    int pulses, chgs, idx;

    always #5 clk = ~clk;

    mos_strength_receiver #(
        .N_DRV       (N_DRV),
        .FILT        (FILT),
        .KEEP_CYCLES (KEEP_CYCLES)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .drv_i           (drv),
        .keeper_en       (keeper_en),
        .resolved_o      (resolved_o),
        .level_o         (level_o),
        .valid_o         (valid_o),
        .contention_o    (contention_o),
        .float_timeout_o (float_timeout_o),
        .change_o        (change_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_resolve(input logic [N_DRV-1:0][1:0] d);
        int n0 = 0, n1 = 0, nx = 0;
        for (int i = 0; i < N_DRV; i++) begin
            if (d[i] == 2'(ST0)) n0++;
            if (d[i] == 2'(ST1)) n1++;
            if (d[i] == 2'(STX)) nx++;
        end
        if (nx > 0 || (n0 > 0 && n1 > 0)) return 2'(STX);
        if (n0 > 0) return 2'(ST0);
        if (n1 > 0) return 2'(ST1);
        return 2'(STZ);
    endfunction

    task automatic model_edge();
        logic       acc;
        logic [1:0] cand;
        m_tmo = 1'b0;
        m_chg = 1'b0;
        if (rst) begin
            hist.delete();
            m_res = 2'(STZ); m_level = 1'b0; m_valid = 1'b0; m_cont = 1'b0;
            m_driving = 1'b0; m_keeping = 1'b0; m_left = 0;
        end else begin
            // accepted when the last FILT net samples agree and differ from the current value
            acc  = 1'b0;
            cand = 2'(STZ);
            if (hist.size() >= FILT) begin
                cand = hist[hist.size()-1];
                acc  = 1'b1;
                for (int i = 1; i <= FILT; i++)
                    if (hist[hist.size()-i] != cand) acc = 1'b0;
                if (cand == m_res) acc = 1'b0;
            end
            if (acc && (cand == 2'(ST0) || cand == 2'(ST1))) begin
                m_chg = (m_level != (cand == 2'(ST1)));
                m_level = (cand == 2'(ST1));
                m_valid = 1'b1; m_res = cand; m_cont = 1'b0;
                m_driving = 1'b1; m_keeping = 1'b0;
            end else if (acc && cand == 2'(STX)) begin
                m_res = cand; m_cont = 1'b1; m_valid = 1'b0;
                m_driving = 1'b0; m_keeping = 1'b0;
            end else if (acc) begin
                m_res = cand; m_cont = 1'b0;
                if (m_driving && keeper_en) begin
                    m_keeping = 1'b1; m_left = KEEP_CYCLES;
                end else begin
                    m_keeping = 1'b0; m_valid = 1'b0;
                end
                m_driving = 1'b0;
            end else if (m_keeping) begin
                if (!keeper_en) begin
                    m_keeping = 1'b0; m_valid = 1'b0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_keeping = 1'b0; m_valid = 1'b0; m_tmo = 1'b1;
                    end
                end
            end
            hist.push_back(ref_resolve(drv));
            while (hist.size() > FILT) void'(hist.pop_front());
        end
    endtask

    task automatic chk_all();
        chk("resolved", 32'(resolved_o), 32'(m_res));
        chk("level", 32'(level_o), 32'(m_level));
        chk("valid", 32'(valid_o), 32'(m_valid));
        chk("contention", 32'(contention_o), 32'(m_cont));
        chk("timeout", 32'(float_timeout_o), 32'(m_tmo));
        chk("change", 32'(change_o), 32'(m_chg));
    endtask

    task automatic cycle(input logic [N_DRV-1:0][1:0] d, input logic ken, input logic r);
        @(negedge clk);
        drv       = d;
        keeper_en = ken;
        rst       = r;
        @(posedge clk);
        model_edge();
        #1;
        chk_all();
        if (float_timeout_o) pulses++;
        if (change_o) chgs++;
    endtask

    function automatic logic [N_DRV-1:0][1:0] rand_pat();
        logic [N_DRV-1:0][1:0] d;
        int k;
        int p;
        for (int i = 0; i < N_DRV; i++) d[i] = 2'(STZ);
        k = int'($urandom_range(0, 9));
        p = int'($urandom_range(0, N_DRV-1));
        if (k <= 2)      d[p] = 2'(ST1);
        else if (k <= 5) d[p] = 2'(ST0);
        else if (k == 7) begin
            d[p] = 2'(ST1);
            d[(p + 1) % N_DRV] = 2'(ST1);
        end else if (k == 8) begin
            for (int i = 0; i < N_DRV; i++) d[i] = 2'($urandom_range(0, 3));
        end else if (k == 9) d[p] = 2'(STX);
        return d;
    endfunction

    localparam logic [N_DRV-1:0][1:0] P_Z   = {STZ, STZ, STZ, STZ};
    localparam logic [N_DRV-1:0][1:0] P_1   = {STZ, STZ, STZ, ST1};
    localparam logic [N_DRV-1:0][1:0] P_0   = {STZ, STZ, STZ, ST0};
    localparam logic [N_DRV-1:0][1:0] P_0Z  = {ST0, STZ, STZ, STZ};
    localparam logic [N_DRV-1:0][1:0] P_01  = {ST0, ST1, STZ, STZ};

    initial begin
        logic [N_DRV-1:0][1:0] pat;
        logic ken;
        int   hold;

        cycle(P_Z, 1'b1, 1'b1);
        cycle(P_Z, 1'b1, 1'b1);
        chk("rst_resolved", 32'(resolved_o), 32'(STZ));
        chk("rst_valid", 32'(valid_o), 32'd0);

        // St1 on one driver: accepted after FILT stable samples
        pulses = 0; chgs = 0;
        for (int i = 0; i < 3; i++) cycle(P_1, 1'b1, 1'b0);
        chk("tp1_resolved", 32'(resolved_o), 32'(ST1));
        chk("tp1_level", 32'(level_o), 32'd1);
        chk("tp1_valid", 32'(valid_o), 32'd1);
        chk("tp1_change_cnt", 32'(chgs), 32'd1);
        cycle(P_1, 1'b1, 1'b0);

        // keeper holds for KEEP_CYCLES after the Z acceptance, then times out
        pulses = 0; idx = -1;
        for (int i = 0; i < 12; i++) begin
            cycle(P_Z, 1'b1, 1'b0);
            if (float_timeout_o) idx = i;
        end
        chk("tp2_pulse_cnt", 32'(pulses), 32'd1);
        chk("tp2_pulse_at", 32'(idx), 32'd10);
        chk("tp2_level", 32'(level_o), 32'd1);
        chk("tp2_valid", 32'(valid_o), 32'd0);

        // contention, then a clean St0
        for (int i = 0; i < 3; i++) cycle(P_01, 1'b1, 1'b0);
        chk("tp3_cont", 32'(contention_o), 32'd1);
        chk("tp3_valid", 32'(valid_o), 32'd0);
        chk("tp3_level", 32'(level_o), 32'd1);
        chgs = 0;
        for (int i = 0; i < 3; i++) cycle(P_0Z, 1'b1, 1'b0);
        chk("tp3b_cont", 32'(contention_o), 32'd0);
        chk("tp3b_level", 32'(level_o), 32'd0);
        chk("tp3b_change_cnt", 32'(chgs), 32'd1);

        // one-cycle St0 glitch on an St1 net
        for (int i = 0; i < 4; i++) cycle(P_1, 1'b1, 1'b0);
        chgs = 0;
        cycle(P_0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(P_1, 1'b1, 1'b0);
        chk("tp4_change_cnt", 32'(chgs), 32'd0);
        chk("tp4_level", 32'(level_o), 32'd1);

        // St1 accepted on the keeper's last cycle wins over expiry
        pulses = 0; chgs = 0;
        for (int i = 0; i < 8; i++) cycle(P_Z, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(P_1, 1'b1, 1'b0);
        chk("tp5_pulse_cnt", 32'(pulses), 32'd0);
        chk("tp5_change_cnt", 32'(chgs), 32'd0);
        chk("tp5_valid", 32'(valid_o), 32'd1);

        // reset while the keeper is at count 4
        for (int i = 0; i < 7; i++) cycle(P_Z, 1'b1, 1'b0);
        chk("tp6_pre_valid", 32'(valid_o), 32'd1);
        cycle(P_Z, 1'b1, 1'b1);
        chk("tp6_resolved", 32'(resolved_o), 32'(STZ));
        chk("tp6_level", 32'(level_o), 32'd0);
        chk("tp6_valid", 32'(valid_o), 32'd0);
        chk("tp6_timeout", 32'(float_timeout_o), 32'd0);
        chk("tp6_change", 32'(change_o), 32'd0);

        // randomized patterns with random hold lengths
        ken = 1'b1;
        for (int n = 0; n < 300; n++) begin
            pat  = rand_pat();
            hold = int'($urandom_range(1, 14));
            if ($urandom_range(0, 7) == 0) ken = ~ken;
            for (int h = 0; h < hold; h++) begin
                cycle(pat, ken, ($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0);
                if ($urandom_range(0, 19) == 0) ken = ~ken;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
